mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front-end for the MEM stage of the 5-stage pipeline. It accepts one memory request at a time from the EX/MEM pipeline register and performs byte, halfword and word loads and stores against the word-organised data memory. Sub-word stores use a two-access read-modify-write; loads are sign- or zero-extended. Results go to MEM/WB with a one-cycle valid pulse, and the unit stalls upstream through `req_ready` while busy.

## Interface
Parameters:
- `DM_DEPTH`, 256: number of 32-bit words in data memory; must be a power of 2.
- `AW`, 32: byte-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present from EX/MEM.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_read` in 1: load request.
- `req_write` in 1: store request.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend load (lbu/lhu).
- `req_addr` in AW: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in 5: destination register tag, passed through.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores/faults.
- `resp_rd` out 5: tag of completed request.
- `resp_fault` out 1: misaligned/illegal/out-of-range, qualified by `resp_valid`.
- `dm_addr` out AW: word-aligned byte address (low 2 bits 0).
- `dm_wdata` out 32: write data.
- `dm_we` out 1: write; memory commits at rising edge ending the cycle.
- `dm_re` out 1: read; `dm_rdata` valid during the following cycle.
- `dm_rdata` in 32: memory read data.

## Operation
- Accept when `req_valid && req_ready`; latch all `req_*` fields.
- Lanes little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- Fault if: size 11; half with `addr[0]`=1; word with `addr[1:0]`≠0; `req_read && req_write`; `addr >= 4*DM_DEPTH`. A faulting request makes no memory access.
- Neither `req_read` nor `req_write`: accepted as no-op, no response.
- FSM states: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR.
  - IDLE: accept → LD_RD (load), ST_WR (word store), RMW_RD (byte/half store); fault → stays IDLE, response registered.
  - LD_RD: `dm_re`=1 → LD_DATA.
  - LD_DATA: extract lane from `dm_rdata`, extend, register response → IDLE.
  - ST_WR: `dm_we`=1, `dm_wdata`=latched data → IDLE, response registered.
  - RMW_RD: `dm_re`=1 → RMW_WR.
  - RMW_WR: `dm_wdata` = `dm_rdata` with target lane(s) replaced by low bits of latched data, `dm_we`=1 → IDLE, response registered.
- `dm_re`/`dm_we`/`dm_addr`/`dm_wdata` are decoded from state plus latched registers only, never from `req_*`.
- Outside LD_RD/RMW_RD `dm_re`=0; outside ST_WR/RMW_WR `dm_we`=0.

## Timing
- Accept at edge N; load: `resp_valid` in cycle N+3; word store: N+2; sub-word store: N+3; fault: N+1.
- `resp_*` are registered; `resp_valid` lasts exactly one cycle; `resp_rdata`/`resp_fault` cleared to 0 when `resp_valid`=0.
- `req_ready` rises in the cycle `resp_valid` is high; back-to-back requests lose no extra cycle.
- Reset: state IDLE; `req_ready`=1 the cycle after reset; `resp_valid`, `resp_fault`, `dm_we`, `dm_re`=0; `resp_rdata`, `resp_rd`, `dm_addr`, `dm_wdata`=0.
- Reset mid-operation: a write whose cycle is in progress when `rst` is sampled commits (`dm_we` already high). No later access occurs. Reset in RMW_RD means no write and no response.

## Structure
- Package `mem_access_pkg`: size codes, FSM state encoding, `WORD_IDX_W = $clog2(DM_DEPTH)`.
- One sub-module, `mem_lane_align`: combinational load extract/extend and store lane merge, keyed by size, `addr[1:0]`, unsigned.

## Test plan
- Memory preset `DM[i]=i`: lw addr 0x10 → `resp_rdata`=0x00000004, `resp_rd` echoed, at N+3.
- Word 0x20 = 0x000080F0: lb 0x21 → 0xFFFFFF80; lbu 0x21 → 0x00000080; lh 0x20 → 0xFFFF80F0.
- Word 0x30 = 0x11223344: sh 0x32 data 0xCAFEBEEF → word becomes 0xBEEF3344; sb 0x31 data 0xAA → 0xBEEFAA44.
- lw 0x06, lh 0x03, size 11, addr 0x400 (depth 256) → `resp_fault`=1 at N+1, `dm_re`=`dm_we`=0 throughout.
- Three back-to-back lw with `req_valid` held → `req_ready` low during each op, responses exactly 3 cycles apart.
- `rst` asserted in RMW_RD of an sb → no `dm_we`, no `resp_valid`, memory word unchanged, `req_ready`=1 next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mem_access_pkg;

  // Access size codes as carried on req_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_DATA,
    S_ST_WR,
    S_RMW_RD,
    S_RMW_WR
  } state_e;

  localparam int DM_DEPTH_DEF = 256;
  localparam int WORD_IDX_W   = $clog2(DM_DEPTH_DEF);

  // Size/alignment legality; the illegal size code counts as misaligned
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_off,
  input  logic        i_uns,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane out of the memory word and extend it
  always_comb begin
    w_byte = i_rword[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_size)
      SZ_BYTE: o_ld_data = i_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = i_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_ld_data = i_rword;
    endcase
  end

  // Replace only the target lane(s) of the old word with low store bits
  always_comb begin
    o_st_word = i_rword;
    case (i_size)
      SZ_BYTE: o_st_word[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_off[1]) o_st_word[31:16] = i_wdata[15:0];
        else          o_st_word[15:0]  = i_wdata[15:0];
      end
      default: o_st_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: one request at a time, RMW for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_DEPTH = 256,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [4:0]    resp_rd,
  output logic          resp_fault,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  output logic          dm_re,
  input  logic [31:0]   dm_rdata
);

  localparam int L_WORD_IDX_W = $clog2(DM_DEPTH);

  state_e        r_state;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  size_e         r_size;
  logic          r_uns;
  logic [4:0]    r_rd;

  logic          w_oor;
  logic          w_fault;
  logic [31:0]   w_ld_data;
  logic [31:0]   w_st_word;

  // Anything at or above the top of data memory is out of range
  assign w_oor   = (req_addr >> (L_WORD_IDX_W + 2)) != '0;
  // Only real accesses can fault; a no-op is simply swallowed
  assign w_fault = (req_read | req_write) &
                   (misaligned(req_size, req_addr[1:0]) | (req_read & req_write) | w_oor);

  mem_lane_align u_align (
    .i_size   (r_size),
    .i_off    (r_addr[1:0]),
    .i_uns    (r_uns),
    .i_rword  (dm_rdata),
    .i_wdata  (r_wdata),
    .o_ld_data(w_ld_data),
    .o_st_word(w_st_word)
  );

  // Memory strobes come only from state and latched fields
  assign req_ready = (r_state == S_IDLE);
  assign dm_re     = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
  assign dm_we     = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
  assign dm_addr   = {r_addr[AW-1:2], 2'b00};

  // Write data: full word for sw, merged old word for sb/sh
  always_comb begin
    dm_wdata = '0;
    case (r_state)
      S_ST_WR:  dm_wdata = r_wdata;
      S_RMW_WR: dm_wdata = w_st_word;
      default:  dm_wdata = '0;
    endcase
  end

  // Sequencer with registered response; resp_rd holds the last tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_BYTE;
      r_uns      <= 1'b0;
      r_rd       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_rd    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= size_e'(req_size);
            r_uns   <= req_unsigned;
            r_rd    <= req_rd;
            if (w_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rd    <= req_rd;
            end else if (req_read) begin
              r_state <= S_LD_RD;
            end else if (req_write) begin
              r_state <= (req_size == SZ_WORD) ? S_ST_WR : S_RMW_RD;
            end
          end
        end
        S_LD_RD:  r_state <= S_LD_DATA;
        S_LD_DATA: begin
          resp_valid <= 1'b1;
          resp_rdata <= w_ld_data;
          resp_rd    <= r_rd;
          r_state    <= S_IDLE;
        end
        S_RMW_RD: r_state <= S_RMW_WR;
        S_ST_WR, S_RMW_WR: begin
          resp_valid <= 1'b1;
          resp_rd    <= r_rd;
          r_state    <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we, dm_re;

  logic        preload;
  logic [31:0] mem [0:255];
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_DEPTH(256), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_fault(resp_fault),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata)
  );

  // Synchronous memory: write commits at the edge, read data next cycle
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
      mem[8]  <= 32'h0000_80F0;
      mem[12] <= 32'h1122_3344;
    end else begin
      if (dm_we) begin
        mem[dm_addr[9:2]] <= dm_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (dm_re) begin
        dm_rdata <= mem[dm_addr[9:2]];
        re_cnt   <= re_cnt + 1;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tag,
                        output int lat, output logic [31:0] data, output logic flt,
                        output logic [4:0] rtag);
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = wd; req_rd = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    lat = 0; data = '0; flt = 1'b0; rtag = '0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; data = resp_rdata; flt = resp_fault; rtag = resp_rd;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_chk++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_resp_fault got %b exp 0", resp_fault); end
    n_chk++; if ({dm_we, dm_re} !== 2'b00) begin n_fail++; $display("FAIL reset_dm_strobes got %b exp 00", {dm_we, dm_re}); end
    n_chk++; if (resp_rdata !== 32'h0 || resp_rd !== 5'd0) begin n_fail++; $display("FAIL reset_resp_data got %h/%0d exp 0/0", resp_rdata, resp_rd); end
    n_chk++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_bus got %h/%h exp 0/0", dm_addr, dm_wdata); end
  endtask

  task automatic test_load_word();
    int lat; logic [31:0] d; logic f; logic [4:0] t;
    do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd5, lat, d, f, t);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL lw_data got %h exp 00000004", d); end
    n_chk++; if (t !== 5'd5 || f !== 1'b0) begin n_fail++; $display("FAIL lw_tag_fault got %0d/%b exp 5/0", t, f); end
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h21, 32'h21, 32'h20, 32'h22};
    logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_0000};
    int lat; logic [31:0] d; logic f; logic [4:0] t;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 0, sz[i], un[i], ad[i], 32'h0, 5'(i + 10), lat, d, f, t);
      n_chk++;
      if (lat !== 3 || d !== ex[i] || t !== 5'(i + 10))
        begin n_fail++; $display("FAIL load_ext[%0d] got lat %0d data %h tag %0d exp lat 3 data %h tag %0d", i, lat, d, t, ex[i], i + 10); end
    end
  endtask

  task automatic test_store();
    int lat; logic [31:0] d; logic f; logic [4:0] t;
    do_req(0, 1, 2'b01, 0, 32'h32, 32'hCAFE_BEEF, 5'd3, lat, d, f, t);
    n_chk++; if (lat !== 3 || d !== 32'h0 || t !== 5'd3) begin n_fail++; $display("FAIL sh_resp got lat %0d data %h tag %0d exp 3/0/3", lat, d, t); end
    n_chk++; if (mem[12] !== 32'hBEEF_3344) begin n_fail++; $display("FAIL sh_mem got %h exp BEEF3344", mem[12]); end
    do_req(0, 1, 2'b00, 0, 32'h31, 32'h0000_00AA, 5'd4, lat, d, f, t);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d exp 3", lat); end
    n_chk++; if (mem[12] !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL sb_mem got %h exp BEEFAA44", mem[12]); end
    do_req(0, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 5'd6, lat, d, f, t);
    n_chk++; if (lat !== 2 || f !== 1'b0) begin n_fail++; $display("FAIL sw_resp got lat %0d fault %b exp 2/0", lat, f); end
    n_chk++; if (mem[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem got %h exp DEADBEEF", mem[16]); end
    do_req(1, 0, 2'b01, 1, 32'h32, 32'h0, 5'd7, lat, d, f, t);
    n_chk++; if (d !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_readback got %h exp 0000BEEF", d); end
  endtask

  task automatic test_fault();
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        wr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] ad [5] = '{32'h06, 32'h03, 32'h00, 32'h400, 32'h00};
    int lat; logic [31:0] d; logic f; logic [4:0] t;
    int re0, we0;
    re0 = re_cnt; we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      do_req(rd[i], wr[i], sz[i], 0, ad[i], 32'h1234_5678, 5'(i + 20), lat, d, f, t);
      n_chk++;
      if (lat !== 1 || f !== 1'b1 || d !== 32'h0 || t !== 5'(i + 20))
        begin n_fail++; $display("FAIL fault[%0d] got lat %0d fault %b data %h tag %0d exp 1/1/0/%0d", i, lat, f, d, t, i + 20); end
    end
    n_chk++; if (re_cnt !== re0 || we_cnt !== we0) begin n_fail++; $display("FAIL fault_no_access got re %0d we %0d exp 0/0", re_cnt - re0, we_cnt - we0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
    int          idx = 0;
    int          low = 0;
    int          rcyc [$];
    logic [31:0] rdat [$];
    logic        acc;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = addrs[0]; req_rd = 5'd1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (resp_valid) begin rcyc.push_back(cyc); rdat.push_back(resp_rdata); end
      if (!req_ready) low++;
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin req_addr = addrs[idx]; req_rd = 5'(idx + 1); end
        else begin req_valid = 1'b0; req_read = 1'b0; end
      end
      @(negedge clk);
    end
    req_valid = 1'b0; req_read = 1'b0;
    n_chk++; if (rcyc.size() !== 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", rcyc.size()); end
    else begin
      n_chk++; if (rcyc[0] !== 3 || rcyc[1] !== 6 || rcyc[2] !== 9) begin n_fail++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp 3,6,9", rcyc[0], rcyc[1], rcyc[2]); end
      n_chk++; if (rdat[0] !== 32'h1 || rdat[1] !== 32'h2 || rdat[2] !== 32'h3) begin n_fail++; $display("FAIL b2b_data got %h,%h,%h exp 1,2,3", rdat[0], rdat[1], rdat[2]); end
    end
    n_chk++; if (low !== 6) begin n_fail++; $display("FAIL b2b_ready_low got %0d exp 6", low); end
  endtask

  task automatic test_reset_rmw();
    int we0; int nresp = 0; logic [31:0] w0;
    we0 = we_cnt; w0 = mem[12];
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h31; req_wdata = 32'h55; req_rd = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    n_chk++; if (dm_re !== 1'b1) begin n_fail++; $display("FAIL rmw_rd_phase got dm_re %b exp 1", dm_re); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_ready got %b exp 1", req_ready); end
      end
      if (resp_valid) nresp++;
    end
    n_chk++; if (we_cnt !== we0) begin n_fail++; $display("FAIL rst_rmw_write got %0d writes exp 0", we_cnt - we0); end
    n_chk++; if (nresp !== 0) begin n_fail++; $display("FAIL rst_rmw_resp got %0d exp 0", nresp); end
    n_chk++; if (mem[12] !== w0) begin n_fail++; $display("FAIL rst_rmw_mem got %h exp %h", mem[12], w0); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_fault();
    test_back_to_back();
    test_reset_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
